// File: rtl/spi_slave.sv
// spi_slave: mode-configurable SPI slave.
// SCK, NSS and MOSI are resynchronised into clk_i, and SCK edges are found
// by comparing against a delayed copy. Words are 8/16/24/32 bits long and
// can be sent MSB-first or LSB-first.
// SPI_SLAVE_IRQ_EN: when defined, irq_o is a sticky flag. It is set by
// rx_valid_o or tx_udr_o and cleared by irq_clr_i. When the macro is not
// defined, irq_o is tied low.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_cpol_i,
    input  logic        cfg_cpha_i,
    input  logic        cfg_lsb_i,
    input  logic [1:0]  cfg_len_i,
    input  logic [31:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        tx_udr_o,
    output logic        busy_o,
    input  logic        spi_sck_i,
    input  logic        spi_nss_i,
    input  logic [3:0]  spi_io_in_i,
    output logic [3:0]  spi_io_out_o,
    output logic [3:0]  spi_io_en_o,
    output logic        irq_o,
    input  logic        irq_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] nss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   nss_prev_q;
    logic                   nss_armed_q;
    logic                   cpol_q;
    logic                   cpha_q;
    logic                   lsb_q;
    logic [1:0]             len_q;
    logic [31:0]            tx_sr_q;
    logic [31:0]            rx_sr_q;
    logic [31:0]            rx_data_q;
    logic [5:0]             cnt_q;
    logic                   miso_q;
    logic                   en_q;
    logic                   busy_q;
    logic                   tx_ready_q;
    logic                   tx_udr_q;
    logic                   rx_valid_q;

    logic        sck_s, nss_s, mosi_s;
    logic        sck_rise_s, sck_fall_s, lead_s, trail_s;
    logic        sample_s, shift_s, nss_fall_s, word_done_s;
    logic [2:0]  words_s, load_words_s;
    logic [5:0]  nbits_s, load_nbits_s, rx_shamt_s, load_shamt_s;
    logic [31:0] tx_word_s, tx_align_s, tx_shifted_s, rx_shifted_s, rx_word_d;
    logic        tx_first_s, tx_cur_s, tx_next_s;
    logic        unused_s;

    // Resynchronise the asynchronous SPI pins into clk_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_sync_q  <= {SYNC_STAGES{1'b0}};
            nss_sync_q  <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_io_in_i[0]};
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign nss_s  = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Leading edge moves SCK away from its idle level; CPHA picks which edge samples.
    assign sck_rise_s = sck_s & ~sck_prev_q;
    assign sck_fall_s = ~sck_s & sck_prev_q;
    assign lead_s     = cpol_q ? sck_fall_s : sck_rise_s;
    assign trail_s    = cpol_q ? sck_rise_s : sck_fall_s;
    assign sample_s   = cpha_q ? trail_s : lead_s;
    assign shift_s    = cpha_q ? lead_s : trail_s;
    // A falling edge counts only after NSS has been seen high since reset.
    assign nss_fall_s = nss_prev_q & ~nss_s;

    // Word length in bits for the latched and for the incoming configuration.
    assign words_s      = {1'b0, len_q} + 3'd1;
    assign nbits_s      = {words_s, 3'b000};
    assign load_words_s = {1'b0, cfg_len_i} + 3'd1;
    assign load_nbits_s = {load_words_s, 3'b000};
    assign rx_shamt_s   = 6'd32 - nbits_s;
    assign load_shamt_s = 6'd32 - load_nbits_s;
    assign word_done_s  = (cnt_q == nbits_s);

    // MSB-first words are left-justified so the outgoing bit is always bit 31.
    assign tx_word_s    = tx_valid_i ? tx_data_i : 32'd0;
    assign tx_align_s   = cfg_lsb_i ? tx_word_s : (tx_word_s << load_shamt_s);
    assign tx_first_s   = cfg_lsb_i ? tx_align_s[0] : tx_align_s[31];
    assign tx_cur_s     = lsb_q ? tx_sr_q[0] : tx_sr_q[31];
    assign tx_next_s    = lsb_q ? tx_sr_q[1] : tx_sr_q[30];
    assign tx_shifted_s = lsb_q ? {1'b0, tx_sr_q[31:1]} : {tx_sr_q[30:0], 1'b0};

    // LSB-first bits enter at the top and are right-aligned when the word completes.
    assign rx_shifted_s = lsb_q ? {mosi_s, rx_sr_q[31:1]} : {rx_sr_q[30:0], mosi_s};
    assign rx_word_d    = lsb_q ? (rx_sr_q >> rx_shamt_s) : rx_sr_q;

    // Transfer state machine with shift registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            sck_prev_q  <= 1'b0;
            nss_prev_q  <= 1'b0;
            nss_armed_q <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            len_q       <= 2'd0;
            tx_sr_q     <= 32'd0;
            rx_sr_q     <= 32'd0;
            rx_data_q   <= 32'd0;
            cnt_q       <= 6'd0;
            miso_q      <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            tx_udr_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            sck_prev_q  <= sck_s;
            nss_prev_q  <= nss_s;
            nss_armed_q <= nss_armed_q | nss_s;
            busy_q      <= ~nss_s & nss_armed_q;
            en_q        <= ~nss_s & nss_armed_q;
            tx_ready_q  <= 1'b0;
            tx_udr_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            if (nss_s) begin
                // Deselect: drop any partial word and release MISO.
                state_q <= ST_IDLE;
                cnt_q   <= 6'd0;
                rx_sr_q <= 32'd0;
                tx_sr_q <= 32'd0;
                miso_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (nss_fall_s) begin
                            state_q <= ST_LOAD;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_LOAD: begin
                        cpol_q     <= cfg_cpol_i;
                        cpha_q     <= cfg_cpha_i;
                        lsb_q      <= cfg_lsb_i;
                        len_q      <= cfg_len_i;
                        tx_sr_q    <= tx_align_s;
                        miso_q     <= tx_first_s;
                        rx_sr_q    <= 32'd0;
                        cnt_q      <= 6'd0;
                        tx_ready_q <= tx_valid_i;
                        tx_udr_q   <= ~tx_valid_i;
                        state_q    <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (word_done_s) begin
                            rx_data_q  <= rx_word_d;
                            rx_valid_q <= 1'b1;
                            state_q    <= ST_LOAD;
                        end else begin
                            if (sample_s) begin
                                rx_sr_q <= rx_shifted_s;
                                cnt_q   <= cnt_q + 6'd1;
                            end
                            // In CPHA=0 the trailing edge left over from the previous
                            // word arrives before any sample; it must not shift.
                            if (shift_s && (cpha_q || (cnt_q != 6'd0))) begin
                                miso_q  <= cpha_q ? tx_cur_s : tx_next_s;
                                tx_sr_q <= tx_shifted_s;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic irq_q;

    // Sticky interrupt flag; a new event wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_q <= 1'b0;
        end else if (rx_valid_q || tx_udr_q) begin
            irq_q <= 1'b1;
        end else if (irq_clr_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_q;
        end
    end

    assign irq_o    = irq_q;
    assign unused_s = ^spi_io_in_i[3:1];
`else
    assign irq_o    = 1'b0;
    assign unused_s = ^{spi_io_in_i[3:1], irq_clr_i};
`endif

    assign tx_ready_o   = tx_ready_q;
    assign tx_udr_o     = tx_udr_q;
    assign rx_valid_o   = rx_valid_q;
    assign rx_data_o    = rx_data_q;
    assign busy_o       = busy_q;
    assign spi_io_out_o = {2'b00, miso_q, 1'b0};
    assign spi_io_en_o  = {2'b00, en_q, 1'b0};

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: a bit-banged SPI master plus a word-level model of the slave.
// Each word the master sends must appear once on rx_data_o. Each LOAD pops
// the TX FIFO, or it underruns and the master reads zero.
module tb_spi_slave;
    localparam int SYNC = 2;
    localparam int H    = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i, cfg_cpol_i, cfg_cpha_i, cfg_lsb_i;
    logic [1:0]  cfg_len_i;
    logic [31:0] tx_data_i;
    logic        tx_valid_i, tx_ready_o;
    logic [31:0] rx_data_o;
    logic        rx_valid_o, tx_udr_o, busy_o;
    logic        spi_sck_i, spi_nss_i;
    logic [3:0]  spi_io_in_i, spi_io_out_o, spi_io_en_o;
    logic        irq_o, irq_clr_i;

    int          checks = 0;
    int          errors = 0;
    int          rdy_cnt = 0;
    int          udr_cnt = 0;
    logic        irq_exp = 1'b0;
    logic [31:0] tx_q[$];
    logic [31:0] exp_rx[$];
    logic [31:0] mosi_w[4];
    logic [31:0] tx_w[4];
    logic [31:0] rd_w[4];
    int          ntx;

    always #5 clk_i = ~clk_i;

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cfg_cpol_i(cfg_cpol_i), .cfg_cpha_i(cfg_cpha_i),
        .cfg_lsb_i(cfg_lsb_i), .cfg_len_i(cfg_len_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .tx_udr_o(tx_udr_o),
        .busy_o(busy_o), .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i),
        .spi_io_in_i(spi_io_in_i), .spi_io_out_o(spi_io_out_o),
        .spi_io_en_o(spi_io_en_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // TX producer: offers the FIFO head, garbage data when empty.
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = 32'd0;
        forever begin
            @(posedge clk_i);
            #1;
            if (tx_ready_o && (tx_q.size() > 0)) void'(tx_q.pop_front());
            tx_valid_i = (tx_q.size() > 0);
            tx_data_i  = tx_valid_i ? tx_q[0] : $urandom;
        end
    end

    // Per-cycle compare against the word-level model.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            irq_exp = 1'b0;
            check("reset_rx_data", rx_data_o, 32'd0);
            check("reset_ctl", {19'd0, tx_ready_o, rx_valid_o, tx_udr_o, busy_o, irq_o,
                                spi_io_out_o, spi_io_en_o}, 32'd0);
        end else begin
            check("unused_pins", {26'd0, spi_io_out_o[3:2], spi_io_out_o[0],
                                  spi_io_en_o[3:2], spi_io_en_o[0]}, 32'd0);
            if (!spi_io_en_o[1]) check("miso_idle", {31'd0, spi_io_out_o[1]}, 32'd0);
            if (rx_valid_o) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got rx_valid with %h, required no pulse", rx_data_o);
                end else begin
                    check("rx_word", rx_data_o, exp_rx.pop_front());
                end
            end
            if (tx_ready_o) rdy_cnt++;
            if (tx_udr_o) udr_cnt++;
            check("irq", {31'd0, irq_o}, {31'd0, irq_exp});
`ifdef SPI_SLAVE_IRQ_EN
            if (rx_valid_o || tx_udr_o) irq_exp = 1'b1;
            else if (irq_clr_i) irq_exp = 1'b0;
`endif
        end
    end

    // One SPI bit as seen by the master.
    task automatic xfer_bit(input bit cpol, input bit cpha, input bit mo, output bit mi);
        if (!cpha) begin
            spi_io_in_i[0] = mo;
            wait_clks(H);
            mi = spi_io_out_o[1];
            spi_sck_i = ~cpol;
            wait_clks(H);
            spi_sck_i = cpol;
        end else begin
            spi_sck_i = ~cpol;
            spi_io_in_i[0] = mo;
            wait_clks(H);
            mi = spi_io_out_o[1];
            spi_sck_i = cpol;
            wait_clks(H);
        end
    endtask

    // One NSS-low session of nwords words (or abort_bits bits of one word).
    task automatic session(input bit cpol, input bit cpha, input bit lsb, input logic [1:0] len,
                           input int nwords, input int abort_bits, input string tag);
        int n, nb, idx, loads, exp_rdy;
        logic [31:0] mask, g;
        bit mi;
        n    = 8 * (int'(len) + 1);
        mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        cfg_cpol_i = cpol; cfg_cpha_i = cpha; cfg_lsb_i = lsb; cfg_len_i = len;
        spi_sck_i = cpol;
        wait_clks(6);
        tx_q.delete();
        for (int k = 0; k < ntx; k++) begin
            g = $urandom;
            tx_q.push_back((tx_w[k] & mask) | (g & ~mask));
        end
        rdy_cnt = 0;
        udr_cnt = 0;
        if (abort_bits == 0)
            for (int k = 0; k < nwords; k++) exp_rx.push_back(mosi_w[k] & mask);
        spi_nss_i = 1'b0;
        wait_clks(2 * H);
        check({tag, "_sel_en"}, {28'd0, spi_io_en_o}, 32'd2);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
        for (int w = 0; w < nwords; w++) begin
            rd_w[w] = 32'd0;
            nb = (abort_bits != 0) ? abort_bits : n;
            for (int b = 0; b < nb; b++) begin
                idx = lsb ? b : (n - 1 - b);
                xfer_bit(cpol, cpha, mosi_w[w][idx], mi);
                rd_w[w][idx] = mi;
            end
        end
        if (abort_bits != 0) begin
            spi_nss_i = 1'b1;
            wait_clks(SYNC + 1);
            check({tag, "_abort_en"}, {28'd0, spi_io_en_o}, 32'd0);
            check({tag, "_abort_busy"}, {31'd0, busy_o}, 32'd0);
            wait_clks(4 * H);
            loads = 1;
        end else begin
            wait_clks(2 * H);
            spi_nss_i = 1'b1;
            wait_clks(4 * H);
            loads = nwords + 1;
            for (int w = 0; w < nwords; w++)
                check({tag, "_master_rd"}, rd_w[w], (w < ntx) ? (tx_w[w] & mask) : 32'd0);
        end
        exp_rdy = (ntx < loads) ? ntx : loads;
        check({tag, "_ready_cnt"}, rdy_cnt, exp_rdy);
        check({tag, "_udr_cnt"}, udr_cnt, loads - exp_rdy);
        check({tag, "_rx_left"}, exp_rx.size(), 32'd0);
        exp_rx.delete();
    endtask

    initial begin
        logic exp_irq_set;
        bit   mi;
        rst_n_i = 1'b0; irq_clr_i = 1'b0;
        cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0; cfg_lsb_i = 1'b0; cfg_len_i = 2'd0;
        spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_io_in_i = 4'b1010;
        wait_clks(4);
        rst_n_i = 1'b1;
        wait_clks(SYNC + 2);
        check("post_reset_rx", rx_data_o, 32'd0);
        check("post_reset_en", {28'd0, spi_io_en_o}, 32'd0);
        check("post_reset_busy", {31'd0, busy_o}, 32'd0);

        // Mode 0, MSB-first, 8 bits.
        ntx = 1; tx_w[0] = 32'hA5; mosi_w[0] = 32'h3C;
        session(1'b0, 1'b0, 1'b0, 2'd0, 1, 0, "m0");
        check("m0_rd_lit", rd_w[0], 32'h0000_00A5);
        check("m0_rx_lit", rx_data_o, 32'h0000_003C);

        // Mode 3, LSB-first, 32 bits.
        ntx = 1; tx_w[0] = 32'h1234_5678; mosi_w[0] = 32'hDEAD_BEEF;
        session(1'b1, 1'b1, 1'b1, 2'd3, 1, 0, "m3");
        check("m3_rd_lit", rd_w[0], 32'h1234_5678);
        check("m3_rx_lit", rx_data_o, 32'hDEAD_BEEF);

        // Two 16-bit words under one NSS.
        ntx = 2; tx_w[0] = 32'h1111; tx_w[1] = 32'h2222;
        mosi_w[0] = 32'hCAFE; mosi_w[1] = 32'h0BAD;
        session(1'b0, 1'b1, 1'b0, 2'd1, 2, 0, "b2b");
        check("b2b_rd0_lit", rd_w[0], 32'h1111);
        check("b2b_rd1_lit", rd_w[1], 32'h2222);
        check("b2b_rx_lit", rx_data_o, 32'h0BAD);

        // Underrun: nothing offered.
        ntx = 0; mosi_w[0] = 32'h5A;
        session(1'b1, 1'b0, 1'b0, 2'd0, 1, 0, "udr");
        check("udr_rd_lit", rd_w[0], 32'h0);
`ifdef SPI_SLAVE_IRQ_EN
        exp_irq_set = 1'b1;
`else
        exp_irq_set = 1'b0;
`endif
        check("udr_irq_lit", {31'd0, irq_o}, {31'd0, exp_irq_set});
        irq_clr_i = 1'b1;
        wait_clks(1);
        irq_clr_i = 1'b0;
        wait_clks(1);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);

        // Abort after 5 of 8 bits, then a clean 0x81 word.
        ntx = 1; tx_w[0] = 32'h77; mosi_w[0] = 32'hFF;
        session(1'b0, 1'b0, 1'b0, 2'd0, 1, 5, "abort");
        ntx = 1; tx_w[0] = 32'h3E; mosi_w[0] = 32'h81;
        session(1'b0, 1'b0, 1'b0, 2'd0, 1, 0, "after_abort");
        check("after_abort_rx_lit", rx_data_o, 32'h81);

        // Reset in the middle of a word, released while NSS stays low.
        cfg_cpol_i = 1'b0; cfg_cpha_i = 1'b0; cfg_lsb_i = 1'b0; cfg_len_i = 2'd0;
        tx_q.delete(); tx_q.push_back(32'h99);
        spi_nss_i = 1'b0;
        wait_clks(2 * H);
        for (int b = 0; b < 3; b++) xfer_bit(1'b0, 1'b0, 1'b1, mi);
        #3 rst_n_i = 1'b0;
        #1;
        check("rst_now_rx", rx_data_o, 32'd0);
        check("rst_now_ctl", {19'd0, tx_ready_o, rx_valid_o, tx_udr_o, busy_o, irq_o,
                              spi_io_out_o, spi_io_en_o}, 32'd0);
        tx_q.delete();
        wait_clks(3);
        rst_n_i = 1'b1;
        rdy_cnt = 0; udr_cnt = 0;
        for (int b = 0; b < 8; b++) xfer_bit(1'b0, 1'b0, b[0], mi);
        wait_clks(2 * H);
        check("rst_held_nss_loads", rdy_cnt + udr_cnt, 32'd0);
        spi_nss_i = 1'b1;
        wait_clks(4 * H);
        ntx = 1; tx_w[0] = 32'hC3; mosi_w[0] = 32'h6D;
        session(1'b0, 1'b0, 1'b0, 2'd0, 1, 0, "after_rst");
        check("after_rst_rx_lit", rx_data_o, 32'h6D);

        // Randomized sessions.
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw  = $urandom_range(1, 3);
            ntx = $urandom_range(0, nw + 1);
            for (int k = 0; k < 4; k++) begin
                tx_w[k]   = $urandom;
                mosi_w[k] = $urandom;
            end
            session(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), nw, 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
